wb_master_arb: RTL and testbench
================================

WB_MASTER_ARB -- requirements
Module: wb_master_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the number of cycles without ack/err before the arbiter forces an error; 0 disables the timeout.
REQ-002 SHALL have clk_i  in  1  clock; all logic on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have m0_cyc_i/m1_cyc_i  in  1  master cycle (m0 = instruction bus, m1 = data bus).
REQ-005 SHALL have m0_stb_i/m1_stb_i  in  1  master strobe.
REQ-006 SHALL have m0_we_i/m1_we_i  in  1  master write enable.
REQ-007 SHALL have m0_sel_i/m1_sel_i  in  4  master byte selects.
REQ-008 SHALL have m0_adr_i/m1_adr_i  in  32  master address.
REQ-009 SHALL have m0_dat_i/m1_dat_i  in  32  master write data.
REQ-010 SHALL have m0_dat_o/m1_dat_o  out  32  read data, both driven from s_dat_i.
REQ-011 SHALL have m0_ack_o/m1_ack_o, m0_err_o/m1_err_o  out  1  per-master ack/err.
REQ-012 SHALL have s_cyc_o, s_stb_o, s_we_o  out  1; s_sel_o  out  4; s_adr_o, s_dat_o  out  32  slave-side bus.
REQ-013 SHALL have s_dat_i  in  32; s_ack_i, s_err_i  in  1  slave response.
REQ-014 SHALL have gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle.

Function
REQ-015 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-016 In IDLE: a request is mN_cyc_i=1. One request -> enter GNTN next cycle. Both -> grant the master not granted most recently. None -> stay in IDLE.
REQ-017 SHALL keep register last_gnt, updated on every entry to GNTN. After reset it is 0, so the first tie goes to m1.
REQ-018 Arbitration latency SHALL be one cycle: slave outputs are all 0 in IDLE, and the bus is driven from the cycle after the request is sampled.
REQ-019 In GNTN, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL be combinational copies of master N's inputs, muxed by the registered grant.
REQ-020 mN_ack_o = s_ack_i & gnt_o[N]. mN_err_o = (s_err_i | timeout pulse) & gnt_o[N]. The non-granted master always sees ack=err=0.
REQ-021 GNTN -> IDLE on the first cycle mN_cyc_i=0. The grant holds across multiple strobes while cyc stays high, so there is no preemption.
REQ-022 Releasing to IDLE and re-arbitrating SHALL take one idle cycle, so back-to-back transfers from different masters are separated by at least one s_cyc_o=0 cycle.
REQ-023 Timeout counter (16 bits): cleared in IDLE, on s_ack_i, on s_err_i, and when s_stb_o=0; otherwise increments while s_cyc_o & s_stb_o.
REQ-024 When the counter equals TIMEOUT-1 and no ack/err is present: a one-cycle err SHALL go to the granted master, s_stb_o SHALL be forced to 0 that cycle, and the counter clears. The grant is unchanged.
REQ-025 s_ack_i/s_err_i arriving in IDLE SHALL be ignored and not forwarded.
REQ-026 Simultaneous s_ack_i and timeout expiry: ack wins, no err, counter clears.

Reset
REQ-027 On rst_i, state SHALL be IDLE, last_gnt=0, counter=0, gnt_o=00, and all s_* and mN_ack_o/mN_err_o outputs 0 immediately (asynchronous).
REQ-028 Reset mid-transfer SHALL abandon the transfer with no ack/err emitted. The first post-reset grant follows REQ-016/017.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the counter width constant (16).
REQ-030 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-031 m1 only, write adr=0x100, dat=0xDEADBEEF, sel=0xF, slave acks 2 cycles later -> gnt_o=10, s_adr_o=0x100, m1_ack_o one cycle, m0_ack_o=0.
REQ-032 m0 and m1 assert cyc in the same cycle after reset -> m1 granted first. After m1 drops cyc: one idle cycle, then m0 granted (gnt_o 10 -> 00 -> 01).
REQ-033 m0 holds cyc for 3 reads at 0x0/0x4/0x8 while m1 requests -> m1 waits until m0_cyc_i=0; m1_ack_o stays 0 throughout.
REQ-034 TIMEOUT=8, slave never acks m1 read -> m1_err_o pulses exactly 8 cycles after the strobe starts, s_stb_o=0 in that cycle, gnt_o stays 10.
REQ-035 rst_i asserted while GNT0 with stb high -> all outputs 0 in the same cycle; after release, m1-only request granted in 1 cycle.
REQ-036 s_ack_i injected in IDLE, and s_ack_i coinciding with the timeout-expiry cycle -> no forwarded ack/err in IDLE; in the coincidence case ack only, no err.

Source files
------------

// File: rtl/wb_master_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_master_arb_pkg
// Desc   : FSM state encoding, counter width and grant decode shared by the
//          two-master Wishbone arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package wb_master_arb_pkg;

    localparam int unsigned c_CNT_W = 16;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_GNT0 = 2'd1;
    localparam logic [1:0] c_ST_GNT1 = 2'd2;

    // One-hot grant vector implied by a state code; unused codes map to idle.
    function automatic logic [1:0] f_state_gnt(input logic [1:0] state);
        logic [1:0] gnt;
        gnt = 2'b00;
        if (state == c_ST_GNT0) begin
            gnt = 2'b01;
        end else if (state == c_ST_GNT1) begin
            gnt = 2'b10;
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module : wb_master_arb
// Desc   : Two-master (instruction/data) Wishbone arbiter, alternating priority
//          on ties, no preemption, with a per-transfer response timeout.
// Rev    : 1.0  initial release
// ============================================================================
module wb_master_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  gnt_o
);

    import wb_master_arb_pkg::*;

    localparam bit                 c_TO_EN   = (TIMEOUT != 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last_gnt;
    logic               w_last_gnt_nxt;
    logic [c_CNT_W-1:0] r_to_cnt;
    logic [c_CNT_W-1:0] w_to_cnt_nxt;

    logic [1:0]         w_gnt;
    logic               w_granted;
    logic               w_mst_cyc;
    logic               w_mst_stb;
    logic               w_mst_we;
    logic [3:0]         w_mst_sel;
    logic [31:0]        w_mst_adr;
    logic [31:0]        w_mst_dat;
    logic               w_to_hit;

    assign w_gnt     = f_state_gnt(r_state);
    assign w_granted = |w_gnt;
    assign gnt_o     = w_gnt;

    // Slave-side request mux, steered only by the registered grant.
    always_comb begin
        w_mst_cyc = 1'b0;
        w_mst_stb = 1'b0;
        w_mst_we  = 1'b0;
        w_mst_sel = 4'h0;
        w_mst_adr = 32'h0;
        w_mst_dat = 32'h0;
        if (w_gnt[0]) begin
            w_mst_cyc = m0_cyc_i;
            w_mst_stb = m0_stb_i;
            w_mst_we  = m0_we_i;
            w_mst_sel = m0_sel_i;
            w_mst_adr = m0_adr_i;
            w_mst_dat = m0_dat_i;
        end else if (w_gnt[1]) begin
            w_mst_cyc = m1_cyc_i;
            w_mst_stb = m1_stb_i;
            w_mst_we  = m1_we_i;
            w_mst_sel = m1_sel_i;
            w_mst_adr = m1_adr_i;
            w_mst_dat = m1_dat_i;
        end
    end

    // A real slave response in the expiry cycle takes precedence over the timeout.
    assign w_to_hit = c_TO_EN && w_granted && w_mst_cyc && w_mst_stb &&
                      !s_ack_i && !s_err_i && (r_to_cnt == c_TO_LAST);

    assign s_cyc_o = w_mst_cyc;
    assign s_stb_o = w_mst_stb & ~w_to_hit;
    assign s_we_o  = w_mst_we;
    assign s_sel_o = w_mst_sel;
    assign s_adr_o = w_mst_adr;
    assign s_dat_o = w_mst_dat;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & w_gnt[0];
    assign m1_ack_o = s_ack_i & w_gnt[1];
    assign m0_err_o = (s_err_i | w_to_hit) & w_gnt[0];
    assign m1_err_o = (s_err_i | w_to_hit) & w_gnt[1];

    always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        if (!w_granted || s_ack_i || s_err_i || !s_stb_o) begin
            w_to_cnt_nxt = '0;
        end else if (s_cyc_o) begin
            w_to_cnt_nxt = r_to_cnt + c_CNT_W'(1);
        end
    end

    // r_last_gnt: 0 = m0 owned the bus last, 1 = m1; a tie goes to the other one.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            c_ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (r_last_gnt) begin
                        w_state_nxt    = c_ST_GNT0;
                        w_last_gnt_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = c_ST_GNT1;
                        w_last_gnt_nxt = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    w_state_nxt    = c_ST_GNT0;
                    w_last_gnt_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    w_state_nxt    = c_ST_GNT1;
                    w_last_gnt_nxt = 1'b1;
                end
            end
            c_ST_GNT0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_GNT1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_last_gnt <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_wb_master_arb
// Desc   : Directed scenarios plus randomized traffic against a reference model
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_master_arb;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_arb #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample;
        @(negedge clk_i);
    endtask

    task automatic idle_inputs;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 4'h0;
        m0_adr_i = 32'h0; m0_dat_i = 32'h0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'h0;
        m1_adr_i = 32'h0; m1_dat_i = 32'h0;
        s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        idle_inputs();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h1234;
        s_ack_i = 1'b1;
        next_cycle();
        sample();
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt_o);
        end
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 71'h0) begin
            n_fail++; $display("FAIL reset_sbus: got cyc=%b stb=%b adr=%h expected all 0",
                               s_cyc_o, s_stb_o, s_adr_o);
        end
        n_checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_resp: got %b expected 0000",
                               {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_single_write;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'hF;
        m1_adr_i = 32'h100; m1_dat_i = 32'hDEADBEEF;
        sample();
        n_checks++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_latency: got gnt=%b cyc=%b expected 00/0", gnt_o, s_cyc_o);
        end
        next_cycle();
        sample();
        n_checks++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !==
            {2'b10, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_bus: got gnt=%b adr=%h dat=%h sel=%h we=%b expected 10/100/deadbeef/f/1",
                               gnt_o, s_adr_o, s_dat_o, s_sel_o, s_we_o);
        end
        next_cycle();
        sample();
        n_checks++;
        if (m1_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_early_ack: got %b expected 0", m1_ack_o);
        end
        next_cycle();
        s_ack_i = 1'b1;
        sample();
        n_checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack: got m1=%b m0=%b expected 1/0", m1_ack_o, m0_ack_o);
        end
        next_cycle();
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        sample();
        n_checks++;
        if (m1_ack_o !== 1'b0 || gnt_o !== 2'b10 || s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_release: got ack=%b gnt=%b cyc=%b expected 0/10/0",
                               m1_ack_o, gnt_o, s_cyc_o);
        end
        next_cycle();
        sample();
        n_checks++;
        if (gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL wr_idle: got %b expected 00", gnt_o);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_tie;
        logic [1:0] exp_gnt [6] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h40;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h80;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end
            sample();
            n_checks++;
            if (gnt_o !== exp_gnt[c]) begin
                n_fail++; $display("FAIL tie_gnt[%0d]: got %b expected %b", c, gnt_o, exp_gnt[c]);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_no_preempt;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0;
        next_cycle();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                m0_adr_i = 32'(4 * i);
                s_ack_i  = (ph == 1);
                s_dat_i  = 32'hA000_0000 + 32'(i);
                sample();
                n_checks++;
                if (gnt_o !== 2'b01 || m1_ack_o !== 1'b0 || s_adr_o !== 32'(4 * i)) begin
                    n_fail++; $display("FAIL np_hold[%0d.%0d]: got gnt=%b m1_ack=%b adr=%h expected 01/0/%h",
                                       i, ph, gnt_o, m1_ack_o, s_adr_o, 32'(4 * i));
                end
                n_checks++;
                if (m0_ack_o !== (ph == 1) || m0_dat_o !== 32'hA000_0000 + 32'(i)) begin
                    n_fail++; $display("FAIL np_read[%0d.%0d]: got ack=%b dat=%h expected %b/%h",
                                       i, ph, m0_ack_o, m0_dat_o, (ph == 1), 32'hA000_0000 + 32'(i));
                end
                next_cycle();
            end
        end
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            n_checks++;
            if (gnt_o !== (c == 0 ? 2'b01 : c == 1 ? 2'b00 : 2'b10) || m1_ack_o !== 1'b0) begin
                n_fail++; $display("FAIL np_handover[%0d]: got gnt=%b m1_ack=%b expected %b/0",
                                   c, gnt_o, m1_ack_o, (c == 0 ? 2'b01 : c == 1 ? 2'b00 : 2'b10));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
        next_cycle();
        for (int c = 1; c <= 12; c++) begin
            sample();
            n_checks++;
            if (m1_err_o !== (c == TO) || s_stb_o !== (c != TO) || gnt_o !== 2'b10) begin
                n_fail++; $display("FAIL to_cycle[%0d]: got err=%b stb=%b gnt=%b expected %b/%b/10",
                                   c, m1_err_o, s_stb_o, gnt_o, (c == TO), (c != TO));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_ack_idle_coincide;
        s_ack_i = 1'b1; s_err_i = 1'b1;
        sample();
        n_checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_resp: got %b expected 0000",
                               {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        next_cycle();
        s_ack_i = 1'b0; s_err_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        next_cycle();
        for (int c = 1; c <= TO + 2; c++) begin
            s_ack_i = (c == TO);
            sample();
            n_checks++;
            if (m0_ack_o !== (c == TO) || m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
                n_fail++; $display("FAIL coincide[%0d]: got ack=%b err=%b stb=%b expected %b/0/1",
                                   c, m0_ack_o, m0_err_o, s_stb_o, (c == TO));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h500;
        next_cycle();
        sample();
        n_checks++;
        if (gnt_o !== 2'b01 || s_stb_o !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre: got gnt=%b stb=%b expected 01/1", gnt_o, s_stb_o);
        end
        #2;
        rst_i = 1'b1;
        s_ack_i = 1'b1;
        #1;
        n_checks++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 77'h0) begin
            n_fail++; $display("FAIL rm_async: got gnt=%b cyc=%b stb=%b ack0=%b err0=%b expected all 0",
                               gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o);
        end
        @(posedge clk_i); #1;
        idle_inputs();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        rst_i = 1'b0;
        next_cycle();
        sample();
        n_checks++;
        if (gnt_o !== 2'b10) begin
            n_fail++; $display("FAIL rm_regrant: got %b expected 10", gnt_o);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    // Reference: owner of the bus, who owned it last, and how many strobe
    // cycles the current access has gone without a slave response.
    task automatic test_random;
        int          own, last, run;
        logic        e_cyc, e_stb, e_we, to;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_dat;
        logic [1:0]  e_gnt;
        logic [140:0] exp_v, got_v;
        do_reset();
        own = 0; last = 0; run = 0;
        for (int n = 0; n < 800; n++) begin
            m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
            m0_we_i  = 1'($urandom); m1_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = ($urandom_range(0, 9) == 0);
            s_err_i  = ($urandom_range(0, 29) == 0);
            sample();
            e_gnt = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
            {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat} = '0;
            if (own == 1) {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat} =
                {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
            if (own == 2) {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat} =
                {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
            to = (own != 0) && e_cyc && e_stb && !s_ack_i && !s_err_i && (run == TO - 1);
            e_stb = e_stb && !to;
            exp_v = {e_gnt, e_cyc, e_stb, e_we, e_sel, e_adr, e_dat,
                     (own == 1) && s_ack_i, (own == 1) && (s_err_i || to),
                     (own == 2) && s_ack_i, (own == 2) && (s_err_i || to),
                     s_dat_i, s_dat_i};
            got_v = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
                     m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", n, got_v, exp_v);
            end
            if (own == 0 || s_ack_i || s_err_i || !e_stb) run = 0;
            else if (e_cyc) run = run + 1;
            if (own == 0) begin
                if (m0_cyc_i && m1_cyc_i) own = (last == 0) ? 2 : 1;
                else if (m0_cyc_i) own = 1;
                else if (m1_cyc_i) own = 2;
                if (own != 0) last = own - 1;
            end else if ((own == 1 && !m0_cyc_i) || (own == 2 && !m1_cyc_i)) begin
                own = 0;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_tie();
        test_no_preempt();
        test_timeout();
        test_ack_idle_coincide();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
